// File: rtl/count_pkg.sv
// count_pkg
//   Shared definitions for the count monitor: default widths, the monitor
//   FSM state encoding and the step classification reported by
//   step_classify.
package count_pkg;

    localparam int unsigned CNT_W_DEF  = 4;
    localparam int unsigned WRAP_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_REPORT
    } state_t;

    // CL_WRAP is also a legal single-step increment (max -> 0).
    typedef enum logic [1:0] {
        CL_HOLD,
        CL_STEP,
        CL_WRAP,
        CL_SKIP
    } step_t;

endpackage

// File: rtl/step_classify.sv
// step_classify
//   Combinational classification of one sample of an up-counter against the
//   previous sample.
//   Ports:
//     prev        previous registered sample
//     prev_vld    prev holds a real sample (low right after reset)
//     count_in    current sample
//     step_class  HOLD / STEP / WRAP / SKIP; HOLD whenever prev_vld is low
module step_classify
    import count_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic [CNT_W-1:0] prev,
    input  logic             prev_vld,
    input  logic [CNT_W-1:0] count_in,
    output step_t            step_class
);

    logic [CNT_W-1:0] prev_plus1;

    // Natural CNT_W-bit overflow gives the modulo 2^CNT_W successor.
    assign prev_plus1 = prev + CNT_W'(1);

    always_comb begin
        step_class = CL_HOLD;
        if (prev_vld) begin
            if (count_in == prev) begin
                step_class = CL_HOLD;
            end else if (count_in == prev_plus1) begin
                step_class = (prev == '1) ? CL_WRAP : CL_STEP;
            end else begin
                step_class = CL_SKIP;
            end
        end
    end

endmodule

// File: rtl/count_monitor.sv
// count_monitor
//   Watches a free-running up-counter, counts its wraps after an arm pulse
//   and raises a held report once the latched wrap limit is reached. Any
//   illegal step is recorded in a sticky error flag.
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     count_in   monitored count
//     limit      wrap limit, latched on arm (0 treated as 1)
//     arm        pulse: start / restart wrap counting
//     evt_ack    acknowledge of a pending report
//     evt_valid  report pending (REPORT state)
//     wrap_cnt   wraps counted since the last arm
//     err_skip   sticky illegal-step flag, cleared by rst or arm
//     busy       high in ARMED or REPORT
module count_monitor
    import count_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned WRAP_W = WRAP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  count_in,
    input  logic [WRAP_W-1:0] limit,
    input  logic              arm,
    input  logic              evt_ack,
    output logic              evt_valid,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err_skip,
    output logic              busy
);

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  prev;
    logic              prev_vld;
    logic [WRAP_W-1:0] lim_q;
    logic [WRAP_W-1:0] lim_n;
    logic [WRAP_W-1:0] wrap_n;
    logic [WRAP_W-1:0] wrap_inc;
    logic [WRAP_W-1:0] lim_sel;
    step_t             step_class;

    step_classify #(
        .CNT_W (CNT_W)
    ) u_step_classify (
        .prev       (prev),
        .prev_vld   (prev_vld),
        .count_in   (count_in),
        .step_class (step_class)
    );

    assign wrap_inc = (wrap_cnt == '1) ? wrap_cnt : wrap_cnt + WRAP_W'(1);
    assign lim_sel  = (limit == '0) ? WRAP_W'(1) : limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        wrap_n    = wrap_cnt;
        lim_n     = lim_q;
        evt_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (arm) begin
                    state_n = ST_ARMED;
                    wrap_n  = '0;
                    lim_n   = lim_sel;
                end
            end
            ST_ARMED: begin
                busy = 1'b1;
                // A restart discards any wrap seen in the same cycle.
                if (arm) begin
                    wrap_n = '0;
                    lim_n  = lim_sel;
                end else if (step_class == CL_WRAP) begin
                    wrap_n = wrap_inc;
                    if (wrap_inc == lim_q) begin
                        state_n = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                busy      = 1'b1;
                evt_valid = 1'b1;
                if (evt_ack) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= '0;
            prev_vld <= 1'b0;
            wrap_cnt <= '0;
            lim_q    <= WRAP_W'(1);
            err_skip <= 1'b0;
        end else begin
            prev     <= count_in;
            prev_vld <= 1'b1;
            wrap_cnt <= wrap_n;
            lim_q    <= lim_n;
            if (arm) begin
                err_skip <= 1'b0;
            end else if (step_class == CL_SKIP) begin
                err_skip <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
module tb_count_monitor;

    localparam int CW   = 4;
    localparam int WW   = 8;
    localparam int CMOD = 1 << CW;
    localparam int WMAX = (1 << WW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] count_in;
    logic [WW-1:0] limit;
    logic          arm;
    logic          evt_ack;
    logic          evt_valid;
    logic [WW-1:0] wrap_cnt;
    logic          err_skip;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state (0 idle, 1 armed, 2 report)
    int m_prev, m_pvld, m_mode, m_wrap, m_lim, m_err;

    typedef struct {
        bit r, a, k;
        int c, l;
        bit ev;
        int wc;
        bit er, bz;
    } vec_t;

    vec_t tbl[$];

    count_monitor #(.CNT_W(CW), .WRAP_W(WW)) dut (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .limit     (limit),
        .arm       (arm),
        .evt_ack   (evt_ack),
        .evt_valid (evt_valid),
        .wrap_cnt  (wrap_cnt),
        .err_skip  (err_skip),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic model_update(input bit r, a, k, input int c, l);
        bit is_wrap, is_skip;
        if (r) begin
            m_prev = 0; m_pvld = 0; m_mode = 0; m_wrap = 0; m_lim = 1; m_err = 0;
            return;
        end
        is_wrap = (m_pvld != 0) && (m_prev == CMOD - 1) && (c == 0);
        is_skip = (m_pvld != 0) && (c != m_prev) && (c != (m_prev + 1) % CMOD);
        if (a) m_err = 0;
        else if (is_skip) m_err = 1;
        case (m_mode)
            0: if (a) begin
                m_mode = 1; m_wrap = 0; m_lim = (l == 0) ? 1 : l;
            end
            1: if (a) begin
                m_wrap = 0; m_lim = (l == 0) ? 1 : l;
            end else if (is_wrap) begin
                m_wrap = (m_wrap + 1 > WMAX) ? WMAX : m_wrap + 1;
                if (m_wrap == m_lim) m_mode = 2;
            end
            default: if (k) m_mode = 0;
        endcase
        m_prev = c;
        m_pvld = 1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive, clock, update model, sample 1 time unit later.
    task automatic apply(input bit r, a, k, input int c, l);
        rst = r; arm = a; evt_ack = k;
        count_in = CW'(c); limit = WW'(l);
        @(posedge clk);
        model_update(r, a, k, c, l);
        #1;
        vectors++;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".evt_valid"}, int'(evt_valid), (m_mode == 2) ? 1 : 0);
        chk({tag, ".wrap_cnt"},  int'(wrap_cnt),  m_wrap);
        chk({tag, ".err_skip"},  int'(err_skip),  m_err);
        chk({tag, ".busy"},      int'(busy),      (m_mode != 0) ? 1 : 0);
    endtask

    task automatic step(input string tag, input bit r, a, k, input int c, l);
        apply(r, a, k, c, l);
        check_model(tag);
        @(negedge clk);
    endtask

    task automatic add(input bit r, a, k, input int c, l, input bit ev, input int wc,
                       input bit er, bz);
        vec_t v;
        v.r = r; v.a = a; v.k = k; v.c = c; v.l = l;
        v.ev = ev; v.wc = wc; v.er = er; v.bz = bz;
        tbl.push_back(v);
    endtask

    initial begin
        int c;
        rst = 1'b1; arm = 1'b0; evt_ack = 1'b0; count_in = '0; limit = '0;
        @(negedge clk);

        // Directed table: skip detection, limit 0 -> 1, ack, stray ack.
        //   r a k  cnt lim   ev wc er bz
        add(1,0,0,  0, 0,    0, 0, 0, 0);
        add(0,1,0,  0, 0,    0, 0, 0, 1);
        add(0,0,0,  1, 0,    0, 0, 0, 1);
        add(0,0,0,  2, 0,    0, 0, 0, 1);
        add(0,0,0,  3, 0,    0, 0, 0, 1);
        add(0,0,0,  4, 0,    0, 0, 0, 1);
        add(0,0,0,  7, 0,    0, 0, 1, 1);
        add(0,0,0,  8, 0,    0, 0, 1, 1);
        add(0,1,0,  9, 0,    0, 0, 0, 1);
        add(0,0,0, 15, 0,    0, 0, 1, 1);
        add(0,0,0,  0, 0,    1, 1, 1, 1);
        add(0,0,0,  1, 0,    1, 1, 1, 1);
        add(0,0,1,  2, 0,    0, 1, 1, 0);
        add(0,1,0,  3, 2,    0, 0, 0, 1);
        add(0,0,1,  3, 0,    0, 0, 0, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].a, tbl[i].k, tbl[i].c, tbl[i].l);
            chk($sformatf("tbl%0d.evt_valid", i), int'(evt_valid), int'(tbl[i].ev));
            chk($sformatf("tbl%0d.wrap_cnt", i),  int'(wrap_cnt),  tbl[i].wc);
            chk($sformatf("tbl%0d.err_skip", i),  int'(err_skip),  int'(tbl[i].er));
            chk($sformatf("tbl%0d.busy", i),      int'(busy),      int'(tbl[i].bz));
            @(negedge clk);
        end

        // Full count sweep, arm at cycle 2 with limit 1.
        step("sweep_rst", 1, 0, 0, 0, 0);
        for (int i = 0; i <= CMOD; i++) begin
            step("sweep", 0, (i == 2), 0, i % CMOD, 1);
        end
        chk("sweep.report", int'(evt_valid), 1);
        chk("sweep.wrap1",  int'(wrap_cnt),  1);
        step("sweep_ack", 0, 0, 1, 1, 0);
        chk("sweep.ack_idle", int'(busy), 0);

        // Limit 3, no ack for a long time: count freezes at 3.
        step("hold_arm", 0, 1, 0, 2, 3);
        c = 2;
        for (int i = 0; i < 3 * CMOD + 40; i++) begin
            c = (c + 1) % CMOD;
            step("hold", 0, 0, 0, c, 0);
        end
        chk("hold.valid", int'(evt_valid), 1);
        chk("hold.wrap3", int'(wrap_cnt),  3);

        // Reset in REPORT together with ack, then an illegal first sample.
        step("rst_rep", 1, 0, 1, 15, 0);
        chk("rst_rep.valid", int'(evt_valid), 0);
        chk("rst_rep.wrap",  int'(wrap_cnt),  0);
        step("post_rst0", 0, 0, 0, 7, 0);
        chk("post_rst0.noskip", int'(err_skip), 0);
        step("post_rst1", 0, 0, 0, 8, 0);

        // Limit 255 with 300 wraps: saturates at the limit, no rollover.
        step("lim255_arm", 0, 1, 0, 15, 255);
        for (int i = 0; i < 600; i++) begin
            step("lim255", 0, 0, 0, (i % 2 == 0) ? 0 : 15, 0);
        end
        chk("lim255.valid", int'(evt_valid), 1);
        chk("lim255.wrap",  int'(wrap_cnt),  255);
        step("lim255_ack", 0, 0, 1, 0, 0);

        // Randomized traffic against the reference model.
        c = 0;
        for (int i = 0; i < 3000; i++) begin
            int sel;
            bit r, a, k;
            sel = int'($urandom_range(0, 99));
            if (sel < 70)      c = (c + 1) % CMOD;
            else if (sel < 90) c = c;
            else               c = int'($urandom_range(0, CMOD - 1));
            r = ($urandom_range(0, 199) == 0);
            a = ($urandom_range(0, 39) == 0);
            k = ($urandom_range(0, 3) == 0);
            step("rand", r, a, k, c, int'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter CNT_W, default 4, width of the monitored count.
REQ-002 Parameter WRAP_W, default 8, width of the wrap counter and limit.
REQ-003 clk  input  1  single clock; all logic rising-edge triggered.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 count_in  input  CNT_W  free-running count from the upstream up-counter.
REQ-006 limit  input  WRAP_W  wrap count that triggers a report; sampled on arm.
REQ-007 arm  input  1  one-cycle pulse; starts or restarts wrap counting.
REQ-008 evt_ack  input  1  consumer acknowledge for evt_valid.
REQ-009 evt_valid  output  1  report pending; held until acknowledged.
REQ-010 wrap_cnt  output  WRAP_W  wraps counted since last arm.
REQ-011 err_skip  output  1  sticky flag: count_in made an illegal step.
REQ-012 busy  output  1  high in ARMED or REPORT.

Function
REQ-013 Every cycle, the block registers count_in as prev and keeps prev_vld, set after the first post-reset sample.
REQ-014 Step classification with prev_vld=1: count_in==prev -> HOLD; count_in==prev+1 mod 2^CNT_W -> STEP; prev==max and count_in==0 -> WRAP (also a STEP); anything else -> SKIP.
REQ-015 With prev_vld=0, no classification occurs: no WRAP, no SKIP.
REQ-016 SKIP sets err_skip on the next edge; err_skip clears only on rst or arm.
REQ-017 FSM states: IDLE, ARMED, REPORT; IDLE after reset.
REQ-018 IDLE: on arm -> ARMED; wrap_cnt cleared; limit latched as lim_q, with limit==0 latched as 1.
REQ-019 ARMED: each WRAP increments wrap_cnt by 1, saturating at 2^WRAP_W-1.
REQ-020 ARMED: when wrap_cnt reaches lim_q, go to REPORT on the same edge that makes the increment.
REQ-021 ARMED: arm restarts the run: wrap_cnt cleared, limit relatched; a WRAP in the same cycle is discarded.
REQ-022 REPORT: evt_valid=1 and wrap_cnt frozen; WRAPs are ignored; arm is ignored.
REQ-023 REPORT: on evt_ack=1 -> IDLE next edge; evt_valid deasserts that edge; wrap_cnt retained until next arm.
REQ-024 evt_ack outside REPORT has no effect.
REQ-025 Latency: WRAP on count_in at edge N is reflected in wrap_cnt at edge N+1; evt_valid rises at edge N+1 when the limit is reached.
REQ-026 err_skip does not alter FSM state or wrap_cnt.

Reset
REQ-027 rst at any cycle, including mid-REPORT, forces: state IDLE, evt_valid 0, wrap_cnt 0, err_skip 0, busy 0, prev 0, prev_vld 0, lim_q 1.
REQ-028 rst takes priority over arm, evt_ack and count_in in the same cycle.

Structure
REQ-029 Package count_pkg holds CNT_W and WRAP_W defaults, the FSM state enum, and the step-class enum (HOLD/STEP/WRAP/SKIP).
REQ-030 Sub-module step_classify (combinational: prev, prev_vld, count_in -> step class) is instantiated once; the FSM and counters live in count_monitor.

Verification
REQ-031 Reset, then count_in 0..15,0 each cycle, arm at cycle 2 with limit=1 -> evt_valid=1 one cycle after the 15->0 sample, wrap_cnt=1; evt_ack -> IDLE, evt_valid=0.
REQ-032 limit=3, continuous counting, no ack for 40 cycles -> evt_valid stays 1, wrap_cnt stays 3 despite further wraps.
REQ-033 count_in 4 -> 7 while ARMED -> err_skip=1 next cycle, wrap_cnt unchanged, state ARMED; arm -> err_skip=0.
REQ-034 limit=0 at arm -> treated as 1; first wrap -> REPORT.
REQ-035 rst asserted in REPORT together with evt_ack -> all outputs at reset values next cycle; first sample after reset produces no WRAP/SKIP even if 15->0.
REQ-036 limit=255, 300 wraps with arm never repeated -> REPORT at wrap 255, wrap_cnt=255, no overflow to 0.
